// File: rtl/fir_tdm_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_tdm_if
// Brief    : Sample, coefficient and result handshake bundle for fir_tdm.
// Revision : 1.0
// ============================================================================
interface fir_tdm_if #(
    parameter int TAPS     = 8,
    parameter int CHANNELS = 2
);
    localparam int CW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1;

    logic signed [15:0] sample_in;
    logic [CW-1:0]      chan_in;
    logic               valid_in;
    logic               ready_in;

    logic               coef_we;
    logic [TW-1:0]      coef_addr;
    logic signed [15:0] coef_data;
    logic               coef_err;

    logic signed [15:0] sample_out;
    logic [CW-1:0]      chan_out;
    logic               sat_flag;
    logic               valid_out;
    logic               ready_out;

    modport master (
        output sample_in, chan_in, valid_in,
        input  ready_in,
        output coef_we, coef_addr, coef_data,
        input  coef_err,
        input  sample_out, chan_out, sat_flag, valid_out,
        output ready_out
    );

    modport slave (
        input  sample_in, chan_in, valid_in,
        output ready_in,
        input  coef_we, coef_addr, coef_data,
        output coef_err,
        output sample_out, chan_out, sat_flag, valid_out,
        input  ready_out
    );
endinterface
`default_nettype wire

// File: rtl/fir_tdm.sv
`default_nettype none
// ============================================================================
// Module   : fir_tdm
// Brief    : Multi-channel time-multiplexed FIR, one 16x16 MAC per cycle.
// Revision : 1.0
// ============================================================================
module fir_tdm #(
    parameter int TAPS     = 8,
    parameter int CHANNELS = 2,
    parameter int ROUND    = 1,
    parameter int SAT      = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    fir_tdm_if.slave   bus
);
    localparam int CW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1;
    localparam int AW = 32 + TW;
    localparam logic signed [AW-1:0] RND_BIAS = AW'((ROUND != 0) ? 16384 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_armed;
    logic signed [15:0] r_x    [CHANNELS][TAPS];
    logic signed [15:0] r_coef [TAPS];
    logic [CW-1:0]      r_ch;
    logic [TW-1:0]      r_k;
    logic signed [AW-1:0] r_acc;
    logic signed [15:0] r_sample_out;
    logic [CW-1:0]      r_chan_out;
    logic               r_sat;
    logic               r_valid_out;
    logic               r_coef_err;

    logic               w_accept;
    logic               w_chan_ok;
    logic               w_last;
    logic signed [15:0] w_coef_sel;
    logic signed [15:0] w_x_sel;
    logic signed [31:0] w_prod;
    logic signed [AW-1:0] w_acc_nxt;
    logic signed [AW-1:0] w_rnd;
    logic signed [AW-1:0] w_r;
    logic               w_ovf;
    logic signed [15:0] w_res;
    logic               w_sat;

    assign bus.ready_in   = (r_state == S_IDLE) && r_armed;
    assign bus.sample_out = r_sample_out;
    assign bus.chan_out   = r_chan_out;
    assign bus.sat_flag   = r_sat;
    assign bus.valid_out  = r_valid_out;
    assign bus.coef_err   = r_coef_err;

    assign w_accept   = bus.valid_in && bus.ready_in;
    assign w_chan_ok  = int'(bus.chan_in) < CHANNELS;
    assign w_last     = (r_k == TW'(TAPS - 1));
    assign w_coef_sel = r_coef[r_k];
    assign w_x_sel    = r_x[r_ch][r_k];
    assign w_prod     = 32'(w_coef_sel) * 32'(w_x_sel);
    assign w_acc_nxt  = r_acc + AW'(w_prod);
    assign w_rnd      = w_acc_nxt + RND_BIAS;
    assign w_r        = w_rnd >>> 15;
    // Result fits in Q1.15 only when every bit above bit 15 repeats the sign.
    assign w_ovf      = !((&w_r[AW-1:15]) || !(|w_r[AW-1:15]));

    always_comb begin
        w_res = w_r[15:0];
        w_sat = 1'b0;
        if ((SAT != 0) && w_ovf) begin
            w_res = w_r[AW-1] ? 16'sh8000 : 16'sh7FFF;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_chan_ok) w_state_nxt = S_MAC;
            S_MAC:   if (w_last) w_state_nxt = S_OUT;
            S_OUT:   if (bus.ready_out) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed      <= 1'b0;
            r_ch         <= '0;
            r_k          <= '0;
            r_acc        <= '0;
            r_sample_out <= '0;
            r_chan_out   <= '0;
            r_sat        <= 1'b0;
            r_valid_out  <= 1'b0;
            r_coef_err   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < TAPS; k++)
                    r_x[c][k] <= '0;
            for (int k = 0; k < TAPS; k++)
                r_coef[k] <= (k == 0) ? 16'sh7FFF : 16'sh0000;
        end else begin
            r_armed    <= 1'b1;
            r_coef_err <= 1'b0;
            // Writes only land while idle so a running MAC never sees a torn set.
            if (bus.coef_we) begin
                if (r_state == S_IDLE) begin
                    if (int'(bus.coef_addr) < TAPS)
                        r_coef[bus.coef_addr] <= bus.coef_data;
                end else begin
                    r_coef_err <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_chan_ok) begin
                        for (int k = TAPS - 1; k > 0; k--)
                            r_x[bus.chan_in][k] <= r_x[bus.chan_in][k-1];
                        r_x[bus.chan_in][0] <= bus.sample_in;
                        r_ch  <= bus.chan_in;
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_sample_out <= w_res;
                        r_sat        <= w_sat;
                        r_chan_out   <= r_ch;
                        r_valid_out  <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.ready_out) r_valid_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
